// File: rtl/hsid_pkg.sv
// rtl/hsid_pkg.sv - shared types and defaults for the HSI spectral distance unit
package hsid_pkg;

    localparam int HSID_DATA_WIDTH_ACC = 48;
    localparam int HSID_DRAIN_CYCLES   = 3;

    typedef enum logic {
        HSID_MSE = 1'b0,
        HSID_MAE = 1'b1
    } hsid_dist_mode_e;

    typedef enum logic [2:0] {
        HSID_IDLE,
        HSID_ACCUM,
        HSID_DRAIN,
        HSID_DIVIDE,
        HSID_HOLD
    } hsid_dist_state_e;

endpackage

// File: rtl/hsid_dist_acc_if.sv
// rtl/hsid_dist_acc_if.sv - band-word input stream and distance result stream
interface hsid_dist_acc_if #(
    parameter int WORD_WIDTH = 32,
    parameter int REF_W      = 8,
    parameter int BAND_W     = 8
);
    logic                  mode;
    logic                  element_valid;
    logic                  element_ready;
    logic                  element_start;
    logic                  element_last;
    logic [WORD_WIDTH-1:0] element_a;
    logic [WORD_WIDTH-1:0] element_b;
    logic [REF_W-1:0]      vctr_ref;
    logic [BAND_W-1:0]     hsi_bands;
    logic                  dist_valid;
    logic                  dist_ready;
    logic [WORD_WIDTH-1:0] dist_value;
    logic [REF_W-1:0]      dist_ref;

    modport master (
        output mode, element_valid, element_start, element_last, element_a, element_b,
               vctr_ref, hsi_bands, dist_ready,
        input  element_ready, dist_valid, dist_value, dist_ref
    );

    modport slave (
        input  mode, element_valid, element_start, element_last, element_a, element_b,
               vctr_ref, hsi_bands, dist_ready,
        output element_ready, dist_valid, dist_value, dist_ref
    );
endinterface

// File: rtl/hsid_div.sv
// rtl/hsid_div.sv - sequential restoring divider, one quotient bit per cycle
module hsid_div #(
    parameter int DIVIDEND_W = 48,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIVISOR_W:0]    shifted_d;
    logic                  take_d;

    // Trial subtraction; a zero divisor always "takes", giving an all-ones quotient
    always_comb begin
        shifted_d = {rem_q, quo_q[DIVIDEND_W-1]};
        take_d    = (shifted_d >= {1'b0, dsr_q});
    end

    // Load on start, then shift one dividend bit into the remainder per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dsr_q  <= divisor_i;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                quo_q <= {quo_q[DIVIDEND_W-2:0], take_d};
                rem_q <= take_d ? DIVISOR_W'(shifted_d - {1'b0, dsr_q})
                                : shifted_d[DIVISOR_W-1:0];
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;
endmodule

// File: rtl/hsid_dist_acc.sv
// rtl/hsid_dist_acc.sv - streaming MSE/MAE spectral distance with mean divider (option: HSID_DIST_MIN_TRACK_EN)
module hsid_dist_acc
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH       = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int DATA_WIDTH_MUL   = 32,
    parameter int DATA_WIDTH_ACC   = HSID_DATA_WIDTH_ACC,
    parameter int HSI_BANDS        = 128,
    parameter int HSI_LIBRARY_SIZE = 256,
    localparam int REF_W           = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hsid_dist_acc_if.slave        bus
`ifdef HSID_DIST_MIN_TRACK_EN
    ,
    input  logic                  min_clear,
    output logic                  min_valid,
    output logic [WORD_WIDTH-1:0] min_value,
    output logic [REF_W-1:0]      min_ref
`endif
);
    localparam int LANES  = WORD_WIDTH / DATA_WIDTH;
    localparam int BAND_W = $clog2(HSI_BANDS) + 1;
    localparam int DIFF_W = DATA_WIDTH + 1;

    hsid_dist_state_e      state_q;
    hsid_dist_mode_e       mode_q;
    logic [REF_W-1:0]      ref_q;
    logic [BAND_W-1:0]     bands_q;
    logic                  element_ready_q;
    logic                  dist_valid_q;
    logic [WORD_WIDTH-1:0] dist_value_q;
    logic [REF_W-1:0]      dist_ref_q;
    logic [1:0]            drain_cnt_q;
    logic                  div_start_q;

    logic                  beat_take_d;
    logic                  p1_valid_q;
    logic                  p1_start_q;
    logic signed [DIFF_W-1:0] p1_diff_q [LANES];
    logic [DATA_WIDTH-1:0]     mag_d  [LANES];
    logic [DATA_WIDTH_MUL-1:0] term_d [LANES];
    logic [DATA_WIDTH_ACC-1:0] lane_sum_d;
    logic                  p2_valid_q;
    logic                  p2_start_q;
    logic [DATA_WIDTH_ACC-1:0] p2_sum_q;
    logic [DATA_WIDTH_ACC:0]   acc_add_d;
    logic [DATA_WIDTH_ACC-1:0] acc_q;

    logic                      div_busy;
    logic                      div_done;
    logic [DATA_WIDTH_ACC-1:0] div_quotient;

    // In IDLE only a start beat opens a vector; everything else is dropped
    assign beat_take_d = bus.element_valid && element_ready_q &&
                         ((state_q == HSID_ACCUM) || bus.element_start);

    // P1: per-lane signed difference
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_start_q <= 1'b0;
            for (int i = 0; i < LANES; i++) p1_diff_q[i] <= '0;
        end else begin
            p1_valid_q <= beat_take_d;
            p1_start_q <= bus.element_start;
            for (int i = 0; i < LANES; i++)
                p1_diff_q[i] <= $signed({1'b0, bus.element_a[i*DATA_WIDTH +: DATA_WIDTH]}) -
                                $signed({1'b0, bus.element_b[i*DATA_WIDTH +: DATA_WIDTH]});
        end
    end

    // P2 combinational: magnitude, then square or pass-through, summed across lanes
    always_comb begin
        lane_sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            mag_d[i]  = p1_diff_q[i][DIFF_W-1] ? DATA_WIDTH'(-p1_diff_q[i]) : DATA_WIDTH'(p1_diff_q[i]);
            term_d[i] = (mode_q == HSID_MAE) ? DATA_WIDTH_MUL'(mag_d[i])
                                             : DATA_WIDTH_MUL'(mag_d[i]) * DATA_WIDTH_MUL'(mag_d[i]);
            lane_sum_d = lane_sum_d + DATA_WIDTH_ACC'(term_d[i]);
        end
        acc_add_d = {1'b0, acc_q} + {1'b0, p2_sum_q};
    end

    // P2 register and P3 saturating accumulator; a start beat restarts the sum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p2_valid_q <= 1'b0;
            p2_start_q <= 1'b0;
            p2_sum_q   <= '0;
            acc_q      <= '0;
        end else begin
            p2_valid_q <= p1_valid_q;
            p2_start_q <= p1_start_q;
            p2_sum_q   <= lane_sum_d;
            if (p2_valid_q)
                acc_q <= p2_start_q ? p2_sum_q :
                         (acc_add_d[DATA_WIDTH_ACC] ? '1 : acc_add_d[DATA_WIDTH_ACC-1:0]);
        end
    end

    hsid_div #(
        .DIVIDEND_W (DATA_WIDTH_ACC),
        .DIVISOR_W  (BAND_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_q),
        .dividend_i (acc_q),
        .divisor_i  (bands_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= HSID_IDLE;
            mode_q          <= HSID_MSE;
            ref_q           <= '0;
            bands_q         <= '0;
            element_ready_q <= 1'b0;
            dist_valid_q    <= 1'b0;
            dist_value_q    <= '0;
            dist_ref_q      <= '0;
            drain_cnt_q     <= '0;
            div_start_q     <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                HSID_IDLE, HSID_ACCUM: begin
                    element_ready_q <= 1'b1;
                    if (beat_take_d) begin
                        if (bus.element_start) begin
                            mode_q  <= hsid_dist_mode_e'(bus.mode);
                            ref_q   <= bus.vctr_ref;
                            bands_q <= bus.hsi_bands;
                        end
                        if (bus.element_last) begin
                            state_q         <= HSID_DRAIN;
                            element_ready_q <= 1'b0;
                            drain_cnt_q     <= '0;
                        end else begin
                            state_q <= HSID_ACCUM;
                        end
                    end
                end
                HSID_DRAIN: begin
                    // Wait for the last beat to reach the accumulator, then kick the divider
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                    if (drain_cnt_q == 2'(HSID_DRAIN_CYCLES - 2)) div_start_q <= 1'b1;
                    if (drain_cnt_q == 2'(HSID_DRAIN_CYCLES - 1)) state_q <= HSID_DIVIDE;
                end
                HSID_DIVIDE: begin
                    if (div_done && !div_busy) begin
                        state_q      <= HSID_HOLD;
                        dist_valid_q <= 1'b1;
                        dist_value_q <= (|div_quotient[DATA_WIDTH_ACC-1:WORD_WIDTH]) ? '1
                                        : div_quotient[WORD_WIDTH-1:0];
                        dist_ref_q   <= ref_q;
                    end
                end
                HSID_HOLD: begin
                    if (bus.dist_ready) begin
                        state_q         <= HSID_IDLE;
                        dist_valid_q    <= 1'b0;
                        element_ready_q <= 1'b1;
                    end
                end
                default: state_q <= HSID_IDLE;
            endcase
        end
    end

    assign bus.element_ready = element_ready_q;
    assign bus.dist_valid    = dist_valid_q;
    assign bus.dist_value    = dist_value_q;
    assign bus.dist_ref      = dist_ref_q;

`ifdef HSID_DIST_MIN_TRACK_EN
    logic                  min_valid_q;
    logic [WORD_WIDTH-1:0] min_value_q;
    logic [REF_W-1:0]      min_ref_q;

    // Running minimum over delivered results; strict compare keeps the earliest tie
    always_ff @(posedge clk) begin
        if (!rst_n || min_clear) begin
            min_valid_q <= 1'b0;
            min_value_q <= '1;
            min_ref_q   <= '0;
        end else if (dist_valid_q && bus.dist_ready &&
                     (!min_valid_q || (dist_value_q < min_value_q))) begin
            min_valid_q <= 1'b1;
            min_value_q <= dist_value_q;
            min_ref_q   <= dist_ref_q;
        end
    end

    assign min_valid = min_valid_q;
    assign min_value = min_value_q;
    assign min_ref   = min_ref_q;
`endif
endmodule

// File: tb/tb_hsid_dist_acc.sv
// tb/tb_hsid_dist_acc.sv - directed self-checking bench for hsid_dist_acc
module tb_hsid_dist_acc;
    import hsid_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hsid_dist_acc_if #(.WORD_WIDTH(32), .REF_W(8), .BAND_W(8)) bus ();

`ifdef HSID_DIST_MIN_TRACK_EN
    logic        min_clear = 1'b0;
    logic        min_valid;
    logic [31:0] min_value;
    logic [7:0]  min_ref;
`endif

    hsid_dist_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef HSID_DIST_MIN_TRACK_EN
        ,
        .min_clear (min_clear),
        .min_valid (min_valid),
        .min_value (min_value),
        .min_ref   (min_ref)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t_last = 0;
    logic [31:0] va [64];
    logic [31:0] vb [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_t1();
        va[0] = 32'h0014_000A; vb[0] = 32'h0011_000C;
        va[1] = 32'h0028_001E; vb[1] = 32'h0024_001E;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 64; i++) begin va[i] = a; vb[i] = b; end
    endtask

    // Called at a negedge; returns at the negedge after the last beat is accepted
    task automatic send(input int n, input bit do_last, input logic md,
                        input logic [7:0] rf, input logic [7:0] bands);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            bus.element_valid = 1'b1;
            bus.element_start = (i == 0);
            bus.element_last  = do_last && (i == n - 1);
            bus.element_a     = va[i];
            bus.element_b     = vb[i];
            bus.mode          = md;
            bus.vctr_ref      = rf;
            bus.hsi_bands     = bands;
            while (!bus.element_ready && w < 100) begin @(negedge clk); w++; end
            if (i == 0) check("beat_ready", 64'(bus.element_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        t_last = cyc;
        bus.element_valid = 1'b0;
        bus.element_start = 1'b0;
        bus.element_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] val, input logic [7:0] rf);
        int w = 0;
        while (!bus.dist_valid && w < 200) begin @(negedge clk); w++; end
        check({tag, "_valid"},   64'(bus.dist_valid), 64'd1);
        check({tag, "_value"},   64'(bus.dist_value), 64'(val));
        check({tag, "_ref"},     64'(bus.dist_ref),   64'(rf));
        check({tag, "_latency"}, 64'(cyc - t_last),   64'd52);
        if (bus.dist_ready) begin
            @(negedge clk);
            check({tag, "_valid_drop"}, 64'(bus.dist_valid),    64'd0);
            check({tag, "_ready_back"}, 64'(bus.element_ready), 64'd1);
        end
    endtask

    task automatic expect_silence(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.dist_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mode = 1'b0; bus.element_valid = 1'b0; bus.element_start = 1'b0;
        bus.element_last = 1'b0; bus.element_a = '0; bus.element_b = '0;
        bus.vctr_ref = '0; bus.hsi_bands = '0; bus.dist_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.element_ready), 64'd0);
        check("rst_valid", 64'(bus.dist_valid),    64'd0);
        check("rst_value", 64'(bus.dist_value),    64'd0);
        check("rst_ref",   64'(bus.dist_ref),      64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(bus.element_ready), 64'd1);

        // 1: MSE, 4 bands: (4+9+0+16)/4 = 7
        load_t1();
        send(2, 1'b1, 1'b0, 8'd5, 8'd4);
        expect_result("mse4", 32'd7, 8'd5);

        // 2: MAE, 4 bands: (2+3+0+4)/4 = 2
        send(2, 1'b1, 1'b1, 8'd6, 8'd4);
        expect_result("mae4", 32'd2, 8'd6);

        // 3: full-scale lanes over 128 bands, plus divisor and quotient boundaries
        fill(32'hFFFF_FFFF, 32'h0);
        send(64, 1'b1, 1'b0, 8'd7, 8'd128);
        expect_result("mse128", 32'hFFFE_0001, 8'd7);
        send(64, 1'b1, 1'b0, 8'd8, 8'd0);
        expect_result("div0", 32'hFFFF_FFFF, 8'd8);
        send(64, 1'b1, 1'b1, 8'd9, 8'd128);
        expect_result("mae128", 32'h0000_FFFF, 8'd9);
        send(1, 1'b1, 1'b0, 8'd10, 8'd1);
        expect_result("qsat", 32'hFFFF_FFFF, 8'd10);

        // 4: result held while dist_ready is low
        load_t1();
        bus.dist_ready = 1'b0;
        send(2, 1'b1, 1'b0, 8'd11, 8'd4);
        expect_result("hold", 32'd7, 8'd11);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.dist_valid),    64'd1);
            check("hold_value", 64'(bus.dist_value),    64'd7);
            check("hold_ref",   64'(bus.dist_ref),      64'd11);
            check("hold_ready", 64'(bus.element_ready), 64'd0);
        end
        bus.dist_ready = 1'b1;
        @(negedge clk);
        check("hs_valid_drop", 64'(bus.dist_valid),    64'd0);
        check("hs_ready_back", 64'(bus.element_ready), 64'd1);

        // 5a: restart mid-vector, only the second vector reports
        va[0] = 32'h0005_0003; vb[0] = 32'h0;
        va[1] = 32'h1000_2000; vb[1] = 32'h0;
        send(2, 1'b0, 1'b0, 8'd3, 8'd4);
        load_t1();
        send(2, 1'b1, 1'b0, 8'd12, 8'd4);
        expect_result("restart", 32'd7, 8'd12);
        expect_silence("restart_single", 80);

        // 5b: reset during DIVIDE drops the vector
        send(2, 1'b1, 1'b0, 8'd13, 8'd4);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(bus.element_ready), 64'd0);
        rst_n = 1'b1;
        expect_silence("midrst_no_result", 80);
        check("midrst_ready_back", 64'(bus.element_ready), 64'd1);

`ifdef HSID_DIST_MIN_TRACK_EN
        // 6: running minimum, earliest tie wins, then clear
        check("min_rst_valid", 64'(min_valid), 64'd0);
        va[0] = 32'h0000_0003; vb[0] = 32'h0;
        send(1, 1'b1, 1'b0, 8'd1, 8'd1);
        expect_result("min_d1", 32'd9, 8'd1);
        va[0] = 32'h0000_0002;
        send(1, 1'b1, 1'b0, 8'd2, 8'd1);
        expect_result("min_d2", 32'd4, 8'd2);
        send(1, 1'b1, 1'b0, 8'd3, 8'd1);
        expect_result("min_d3", 32'd4, 8'd3);
        check("min_valid", 64'(min_valid), 64'd1);
        check("min_value", 64'(min_value), 64'd4);
        check("min_ref",   64'(min_ref),   64'd2);
        min_clear = 1'b1;
        @(negedge clk);
        min_clear = 1'b0;
        check("min_clr_valid", 64'(min_valid), 64'd0);
        check("min_clr_value", 64'(min_value), 64'hFFFF_FFFF);
        check("min_clr_ref",   64'(min_ref),   64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
